// File: rtl/router_pkg.sv
// router_pkg: shared constants and helpers for the 1xN router write-side blocks.
// Holds the default address width, the default watchdog timeout, the width of
// the per-channel soft-reset statistics counters and the timer-width helper.
package router_pkg;

    // Default width of the destination address field carried in the header byte
    localparam int ROUTER_ADDR_W = 2;

    // Default number of consecutive stalled cycles before a FIFO is soft-reset
    localparam int ROUTER_DEF_TIMEOUT = 30;

    // Width of each per-channel soft-reset event counter
    localparam int ROUTER_SR_CNT_W = 8;

    // Per-channel soft-reset event count as seen on the stats bus
    typedef logic [ROUTER_SR_CNT_W-1:0] router_sr_cnt_t;

    // Width of a watchdog timer able to count 0 .. timeout-1.
    // Never returns less than one bit so a tiny timeout still yields a legal vector.
    function automatic int router_tmr_w(input int timeout);
        int w;
        w = $clog2(timeout);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// router_sync_wdog: stall watchdog for one router output channel.
// Counts consecutive stalled cycles (data waiting, receiver not reading) and
// issues a one-cycle soft_reset pulse once the stall has lasted TIMEOUT cycles.
// Any non-stalled cycle clears the count; it never holds.
// Optional feature: ROUTER_SYNC_STATS_EN builds a saturating count of pulses on
// sr_count; without it sr_count is constant zero.
module router_sync_wdog
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_DEF_TIMEOUT,
    parameter int TMR_W   = router_tmr_w(ROUTER_DEF_TIMEOUT)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       stall,
    output logic                       soft_reset,
    output logic [ROUTER_SR_CNT_W-1:0] sr_count
);

    // Timer value reached in the last stalled cycle before the pulse fires
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             fire;

    // The stall has lasted TIMEOUT cycles once this cycle also stalls at the last count
    assign fire = stall && (tmr_q == TMR_LAST);

    // Stall timer and soft_reset pulse; wrapping to zero on fire spaces repeat pulses TIMEOUT apart
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tmr_q      <= '0;
            soft_reset <= 1'b0;
        end else if (!stall) begin
            tmr_q      <= '0;
            soft_reset <= 1'b0;
        end else if (fire) begin
            tmr_q      <= '0;
            soft_reset <= 1'b1;
        end else begin
            tmr_q      <= tmr_q + 1'b1;
            soft_reset <= 1'b0;
        end
    end

`ifdef ROUTER_SYNC_STATS_EN
    router_sr_cnt_t sr_cnt_q;

    // Saturating count of soft-reset events, advanced together with the pulse so it is visible in the pulse cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sr_cnt_q <= '0;
        end else if (fire && (sr_cnt_q != '1)) begin
            sr_cnt_q <= sr_cnt_q + 1'b1;
        end
    end

    assign sr_count = sr_cnt_q;
`else
    assign sr_count = '0;
`endif

endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: parametrised write-side synchronizer for the 1xN router.
// Latches the destination address from each header, steers write_enb and the
// addressed full flag, drives per-channel vld_out, flags out-of-range
// addresses and runs one stall watchdog per output FIFO.
// Optional feature: define ROUTER_SYNC_STATS_EN to build the per-channel
// soft-reset event counters on sr_count (tied to zero otherwise).
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = ROUTER_ADDR_W,
    parameter int TIMEOUT = ROUTER_DEF_TIMEOUT
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              detect_add,
    input  logic [ADDR_W-1:0]                 data_in,
    input  logic                              write_enb_reg,
    input  logic [NUM_CH-1:0]                 read_enb,
    input  logic [NUM_CH-1:0]                 empty,
    input  logic [NUM_CH-1:0]                 full,
    output logic [NUM_CH-1:0]                 vld_out,
    output logic [NUM_CH-1:0]                 write_enb,
    output logic                              fifo_full,
    output logic                              addr_err,
    output logic [NUM_CH-1:0]                 soft_reset,
    output logic [NUM_CH*ROUTER_SR_CNT_W-1:0] sr_count
);

    localparam int TMR_W = router_tmr_w(TIMEOUT);

    // Channel count widened by one bit so NUM_CH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_ok;
    logic              addr_in_range;
    logic [NUM_CH-1:0] stall;

    assign addr_in_range = ({1'b0, data_in} < NUM_CH_EXT);

    // Capture the header address; a new header always wins, even mid-packet, and flags bad addresses for one cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q   <= '0;
            addr_ok  <= 1'b1;
            addr_err <= 1'b0;
        end else begin
            addr_err <= detect_add && !addr_in_range;
            if (detect_add) begin
                addr_q  <= data_in;
                addr_ok <= addr_in_range;
            end
        end
    end

    // Steer the write to the addressed FIFO and return its full flag; an invalid address drops writes and never stalls
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok && (addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    // A channel stalls while it holds data that the receiver is not reading
    assign stall = vld_out & ~read_enb;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .TMR_W   (TMR_W)
        ) u_wdog (
            .clock      (clock),
            .resetn     (resetn),
            .stall      (stall[g]),
            .soft_reset (soft_reset[g]),
            .sr_count   (sr_count[ROUTER_SR_CNT_W*g +: ROUTER_SR_CNT_W])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: directed bench for router_sync_n with NUM_CH=3, ADDR_W=2,
// TIMEOUT=30. Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit later, well away from the next edge.
// With ROUTER_SYNC_STATS_EN defined the saturating stats counters are exercised;
// otherwise sr_count is expected to stay zero.
module tb_router_sync_n;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 30;

    logic                clock;
    logic                resetn;
    logic                detect_add;
    logic [ADDR_W-1:0]   data_in;
    logic                write_enb_reg;
    logic [NUM_CH-1:0]   read_enb;
    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   vld_out;
    logic [NUM_CH-1:0]   write_enb;
    logic                fifo_full;
    logic                addr_err;
    logic [NUM_CH-1:0]   soft_reset;
    logic [NUM_CH*8-1:0] sr_count;

    int checks;
    int errors;

    router_sync_n #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb      (read_enb),
        .empty         (empty),
        .full          (full),
        .vld_out       (vld_out),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .addr_err      (addr_err),
        .soft_reset    (soft_reset),
        .sr_count      (sr_count)
    );

    // Free-running 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic da, input logic [ADDR_W-1:0] din,
                                 input logic wer, input logic [NUM_CH-1:0] re,
                                 input logic [NUM_CH-1:0] emp, input logic [NUM_CH-1:0] ful);
        detect_add    = da;
        data_in       = din;
        write_enb_reg = wer;
        read_enb      = re;
        empty         = emp;
        full          = ful;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [NUM_CH-1:0] exp_sr;
        checks = 0;
        errors = 0;

        // Reset with every FIFO empty so no watchdog runs
        resetn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 3'b111, '0);
        repeat (3) tick();
        resetn = 1'b1;
        #1;
        checkOutput("reset_write_enb", 32'(write_enb), 32'h0);
        checkOutput("reset_fifo_full", 32'(fifo_full), 32'h0);
        checkOutput("reset_addr_err", 32'(addr_err), 32'h0);
        checkOutput("reset_soft_reset", 32'(soft_reset), 32'h0);
        checkOutput("reset_sr_count", sr_count[31:0] & 32'h00ff_ffff, 32'h0);
        checkOutput("reset_vld_out", 32'(vld_out), 32'h0);

        // Reset address is channel 0 and valid
        applyStimulus(1'b0, '0, 1'b1, '0, 3'b111, 3'b001);
        #1;
        checkOutput("reset_addr_we", 32'(write_enb), 32'h1);
        checkOutput("reset_addr_full", 32'(fifo_full), 32'h1);

        // Header to channel 1, then write with full only on channel 1
        applyStimulus(1'b1, 2'd1, 1'b1, '0, 3'b111, 3'b000);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, '0, 3'b111, 3'b010);
        #1;
        checkOutput("ch1_write_enb", 32'(write_enb), 32'h2);
        checkOutput("ch1_fifo_full", 32'(fifo_full), 32'h1);
        checkOutput("ch1_no_addr_err", 32'(addr_err), 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, '0, 3'b111, 3'b101);
        #1;
        checkOutput("ch1_not_full", 32'(fifo_full), 32'h0);

        // Mid-packet header redirects to channel 2
        applyStimulus(1'b1, 2'd2, 1'b1, '0, 3'b111, 3'b100);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, '0, 3'b111, 3'b100);
        #1;
        checkOutput("redirect_write_enb", 32'(write_enb), 32'h4);
        checkOutput("redirect_fifo_full", 32'(fifo_full), 32'h1);

        // Out-of-range address 3: error pulse, writes dropped, never full
        applyStimulus(1'b1, 2'd3, 1'b1, '0, 3'b111, 3'b111);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, '0, 3'b111, 3'b111);
        #1;
        checkOutput("bad_addr_err", 32'(addr_err), 32'h1);
        checkOutput("bad_write_enb", 32'(write_enb), 32'h0);
        checkOutput("bad_fifo_full", 32'(fifo_full), 32'h0);
        tick();
        checkOutput("bad_addr_err_clear", 32'(addr_err), 32'h0);
        checkOutput("bad_write_enb_hold", 32'(write_enb), 32'h0);

        // Write enable low gives no write even to a valid address
        applyStimulus(1'b1, 2'd0, 1'b0, '0, 3'b111, '0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, '0, 3'b111, '0);
        #1;
        checkOutput("idle_write_enb", 32'(write_enb), 32'h0);

        // Channel 0 stalled from cycle 0: pulses in cycles 30 and 60 only
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, '0);
        #1;
        checkOutput("stall0_vld_out", 32'(vld_out), 32'h1);
        for (int c = 1; c <= 61; c++) begin
            tick();
            exp_sr = (c == 30 || c == 60) ? 3'b001 : 3'b000;
            checkOutput($sformatf("stall0_c%0d", c), 32'(soft_reset), 32'(exp_sr));
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, '0);
        tick();

        // Channel 2: a read in the cycle the count hits 29 suppresses the pulse
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b011, '0);
        for (int c = 1; c <= 61; c++) begin
            tick();
            exp_sr = (c == 60) ? 3'b100 : 3'b000;
            checkOutput($sformatf("stall2_c%0d", c), 32'(soft_reset), 32'(exp_sr));
            read_enb = (c == 29) ? 3'b100 : 3'b000;
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, '0);
        tick();

        // Channels 0 and 1 stalled together pulse together
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b100, '0);
        for (int c = 1; c <= 31; c++) begin
            tick();
            exp_sr = (c == 30) ? 3'b011 : 3'b000;
            checkOutput($sformatf("dual_c%0d", c), 32'(soft_reset), 32'(exp_sr));
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, '0);
        tick();

        // Same pair with reset in cycle 15: no pulse at 30, count restarts so pulse at 46
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b100, '0);
        for (int c = 1; c <= 47; c++) begin
            tick();
            exp_sr = (c == 46) ? 3'b011 : 3'b000;
            checkOutput($sformatf("rst_c%0d", c), 32'(soft_reset), 32'(exp_sr));
            resetn = (c == 15) ? 1'b0 : 1'b1;
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, '0);
        tick();

`ifdef ROUTER_SYNC_STATS_EN
        // Since the mid-run reset only the pulse at 46 counted, on channels 0 and 1
        checkOutput("stats_after_dual", 32'(sr_count), 32'h00_0101);

        // Fresh reset, then 260 timeouts on channel 0 saturate its counter at 255
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        checkOutput("stats_reset", 32'(sr_count), 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, '0);
        repeat (TIMEOUT * 10) tick();
        checkOutput("stats_ten", 32'(sr_count), 32'h00_000a);
        repeat (TIMEOUT * 250) tick();
        checkOutput("stats_saturated", 32'(sr_count), 32'h00_00ff);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, '0);
        tick();
`else
        // Without the stats build the counters read as zero despite all the pulses above
        checkOutput("stats_absent", 32'(sr_count), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
